// File: rtl/gdemux_router.sv
// gdemux_router: one-to-N demultiplexer with a one-word holding register per
// output channel. Supports unicast by selector, broadcast to every channel,
// and flags words addressed to channels that do not exist.
module gdemux_router #(
  parameter int WIDTH  = 16,
  parameter int CANAIS = 4,
  parameter int SEL_W  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         dados_entrada,
  input  logic [SEL_W-1:0]         controle_sel,
  input  logic                     difusao,
  input  logic                     valido_in,
  output logic                     pronto_in,
  output logic [CANAIS*WIDTH-1:0]  canal_dados,
  output logic [CANAIS-1:0]        canal_valido,
  input  logic [CANAIS-1:0]        canal_pronto,
  output logic                     erro_sel
);

  logic [CANAIS-1:0] full_q, full_d;
  logic [WIDTH-1:0]  dado_q [CANAIS];
  logic              erro_q, erro_d;

  logic [CANAIS-1:0] livre;
  logic [CANAIS-1:0] alvo;
  logic [CANAIS-1:0] carga;
  logic              sel_ok;
  logic              sel_livre;
  logic              aceito;

  // Handshake decode: channel freedom, input readiness and per-channel load enables.
  // A channel is free when empty or draining this cycle, so a full channel
  // can be refilled on the same edge it empties.
  always_comb begin
    livre     = ~full_q | canal_pronto;
    alvo      = '0;
    sel_ok    = 1'b0;
    sel_livre = 1'b0;
    for (int i = 0; i < CANAIS; i++) begin
      if (int'(controle_sel) == i) begin
        sel_ok    = 1'b1;
        sel_livre = livre[i];
        alvo[i]   = 1'b1;
      end
    end

    // Out-of-range selectors are always accepted so the word can be dropped.
    if (reset)
      pronto_in = 1'b0;
    else if (difusao)
      pronto_in = &livre;
    else if (sel_ok)
      pronto_in = sel_livre;
    else
      pronto_in = 1'b1;

    aceito = valido_in & pronto_in;
    carga  = '0;
    if (aceito)
      carga = difusao ? {CANAIS{1'b1}} : alvo;

    full_d = carga | (full_q & ~canal_pronto);
    erro_d = aceito & ~difusao & ~sel_ok;
  end

  // Control state: full flags and the error pulse, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q <= '0;
      erro_q <= 1'b0;
    end else begin
      full_q <= full_d;
      erro_q <= erro_d;
    end
  end

  // Holding registers: only written on load; visibility is gated by the full flag.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CANAIS; i++) begin
      if (carga[i])
        dado_q[i] <= dados_entrada;
    end
  end

  // Output view: empty channels read as zero.
  always_comb begin
    canal_dados = '0;
    for (int i = 0; i < CANAIS; i++) begin
      canal_dados[i*WIDTH +: WIDTH] = full_q[i] ? dado_q[i] : '0;
    end
  end

  assign canal_valido = full_q;
  assign erro_sel     = erro_q;

endmodule

// File: tb/tb_gdemux_router.sv
// Self-checking bench for gdemux_router: directed scenarios on a 4-channel
// and a 3-channel instance, plus a randomized soak of an 8-channel instance
// against a per-channel queue scoreboard.
module tb_gdemux_router;

  logic clk;
  logic rst;

  // 4-channel, 16-bit instance
  logic [15:0] a_din;
  logic [1:0]  a_sel;
  logic        a_dif, a_vld, a_pr, a_err;
  logic [63:0] a_cd;
  logic [3:0]  a_cv, a_cp;

  // 3-channel, 16-bit instance
  logic [15:0] b_din;
  logic [1:0]  b_sel;
  logic        b_dif, b_vld, b_pr, b_err;
  logic [47:0] b_cd;
  logic [2:0]  b_cv, b_cp;

  // 8-channel, 8-bit instance
  logic [7:0]  c_din;
  logic [2:0]  c_sel;
  logic        c_dif, c_vld, c_pr, c_err;
  logic [63:0] c_cd;
  logic [7:0]  c_cv, c_cp;

  int n_chk;
  int n_bad;

  gdemux_router #(.WIDTH(16), .CANAIS(4), .SEL_W(2)) dut_a (
    .clk(clk), .reset(rst), .dados_entrada(a_din), .controle_sel(a_sel),
    .difusao(a_dif), .valido_in(a_vld), .pronto_in(a_pr), .canal_dados(a_cd),
    .canal_valido(a_cv), .canal_pronto(a_cp), .erro_sel(a_err)
  );

  gdemux_router #(.WIDTH(16), .CANAIS(3), .SEL_W(2)) dut_b (
    .clk(clk), .reset(rst), .dados_entrada(b_din), .controle_sel(b_sel),
    .difusao(b_dif), .valido_in(b_vld), .pronto_in(b_pr), .canal_dados(b_cd),
    .canal_valido(b_cv), .canal_pronto(b_cp), .erro_sel(b_err)
  );

  gdemux_router #(.WIDTH(8), .CANAIS(8), .SEL_W(3)) dut_c (
    .clk(clk), .reset(rst), .dados_entrada(c_din), .controle_sel(c_sel),
    .difusao(c_dif), .valido_in(c_vld), .pronto_in(c_pr), .canal_dados(c_cd),
    .canal_valido(c_cv), .canal_pronto(c_cp), .erro_sel(c_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard for the 8-channel soak: one queue of pending words per channel.
  logic [7:0]  sbq [8][$];
  logic [15:0] w31 [4];
  logic        exp_pr;
  logic        all_free;
  logic [7:0]  free_v;
  logic [7:0]  ecv;
  logic [63:0] ecd;

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst = 1'b1;
    a_din = '0; a_sel = '0; a_dif = 0; a_vld = 0; a_cp = '0;
    b_din = '0; b_sel = '0; b_dif = 0; b_vld = 0; b_cp = '0;
    c_din = '0; c_sel = '0; c_dif = 0; c_vld = 0; c_cp = '0;

    // Reset state
    @(negedge clk); #1;
    chk("rst_valid", {60'd0, a_cv}, 64'd0);
    chk("rst_data", a_cd, 64'd0);
    chk("rst_err", {63'd0, a_err}, 64'd0);
    chk("rst_pronto", {63'd0, a_pr}, 64'd0);
    chk("rst_valid_c", {56'd0, c_cv}, 64'd0);
    rst = 1'b0;

    // Unicast to each channel on consecutive cycles, all consumers ready
    w31[0] = 16'hA5A5; w31[1] = 16'h5A5A; w31[2] = 16'hFFFF; w31[3] = 16'h0000;
    a_cp = 4'hF;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k < 4) begin
        a_sel = 2'(k); a_din = w31[k]; a_vld = 1'b1;
      end else begin
        a_vld = 1'b0;
      end
      #1;
      if (k < 4) chk("uni_pronto", {63'd0, a_pr}, 64'd1);
      if (k > 0 && k <= 4) begin
        chk("uni_valid", {60'd0, a_cv}, 64'd1 << (k - 1));
        chk("uni_data", a_cd, {48'd0, w31[k-1]} << ((k - 1) * 16));
      end
      if (k == 5) chk("uni_idle", {60'd0, a_cv}, 64'd0);
    end

    // Backpressure on channel 2
    @(negedge clk);
    a_cp = 4'b1011; a_sel = 2'd2; a_din = 16'h1111; a_vld = 1'b1; #1;
    chk("bp_first_pronto", {63'd0, a_pr}, 64'd1);
    @(negedge clk);
    a_din = 16'h2222; #1;
    chk("bp_stall_pronto", {63'd0, a_pr}, 64'd0);
    chk("bp_held_valid", {60'd0, a_cv}, 64'h4);
    chk("bp_held_data", a_cd, 64'h0000_1111_0000_0000);
    @(negedge clk); #1;
    chk("bp_stable_data", a_cd, 64'h0000_1111_0000_0000);
    chk("bp_still_stall", {63'd0, a_pr}, 64'd0);
    a_cp = 4'hF; #1;
    chk("bp_release_pronto", {63'd0, a_pr}, 64'd1);
    @(negedge clk);
    a_vld = 1'b0; #1;
    chk("bp_nobubble_valid", {60'd0, a_cv}, 64'h4);
    chk("bp_second_data", a_cd, 64'h0000_2222_0000_0000);
    @(negedge clk); #1;
    chk("bp_drained", {60'd0, a_cv}, 64'd0);

    // Broadcast blocked by a full, stalled channel 1
    @(negedge clk);
    a_cp = 4'b1101; a_sel = 2'd1; a_din = 16'h0101; a_vld = 1'b1; a_dif = 1'b0; #1;
    chk("bc_prefill_pronto", {63'd0, a_pr}, 64'd1);
    @(negedge clk);
    a_dif = 1'b1; a_din = 16'hBEEF; #1;
    chk("bc_block_pronto", {63'd0, a_pr}, 64'd0);
    @(negedge clk); #1;
    chk("bc_noload_valid", {60'd0, a_cv}, 64'h2);
    chk("bc_noload_data", a_cd, 64'h0000_0000_0101_0000);
    a_cp = 4'hF; #1;
    chk("bc_release_pronto", {63'd0, a_pr}, 64'd1);
    @(negedge clk);
    a_vld = 1'b0; a_dif = 1'b0; #1;
    chk("bc_all_valid", {60'd0, a_cv}, 64'hF);
    chk("bc_all_data", a_cd, 64'hBEEF_BEEF_BEEF_BEEF);
    @(negedge clk); #1;
    chk("bc_drained", {60'd0, a_cv}, 64'd0);

    // Asynchronous reset while channels 0 and 3 hold words
    @(negedge clk);
    a_cp = 4'h0; a_sel = 2'd0; a_din = 16'hAAAA; a_vld = 1'b1;
    @(negedge clk);
    a_sel = 2'd3; a_din = 16'h3333;
    @(negedge clk);
    a_vld = 1'b0; #1;
    chk("ar_full_valid", {60'd0, a_cv}, 64'h9);
    chk("ar_full_data", a_cd, 64'h3333_0000_0000_AAAA);
    #1 rst = 1'b1;
    #1;
    chk("ar_valid_cleared", {60'd0, a_cv}, 64'd0);
    chk("ar_data_cleared", a_cd, 64'd0);
    chk("ar_pronto_low", {63'd0, a_pr}, 64'd0);
    chk("ar_err_low", {63'd0, a_err}, 64'd0);
    rst = 1'b0;
    a_cp = 4'hF; a_sel = 2'd0; a_din = 16'h5555; a_vld = 1'b1; #1;
    chk("ar_post_pronto", {63'd0, a_pr}, 64'd1);
    @(negedge clk);
    a_vld = 1'b0; #1;
    chk("ar_first_accept", {60'd0, a_cv}, 64'h1);
    chk("ar_first_data", a_cd, 64'h0000_0000_0000_5555);

    // 3-channel instance: valid unicast, then a non-existent selector
    @(negedge clk);
    b_cp = 3'b111; b_sel = 2'd2; b_din = 16'h7777; b_vld = 1'b1; #1;
    chk("b_uni_pronto", {63'd0, b_pr}, 64'd1);
    @(negedge clk);
    b_sel = 2'd3; b_din = 16'h1234; #1;
    chk("b_uni_valid", {61'd0, b_cv}, 64'h4);
    chk("b_uni_data", {16'd0, b_cd}, 64'h7777_0000_0000);
    chk("b_bad_pronto", {63'd0, b_pr}, 64'd1);
    chk("b_bad_err_before", {63'd0, b_err}, 64'd0);
    @(negedge clk);
    b_vld = 1'b0; #1;
    chk("b_bad_err_pulse", {63'd0, b_err}, 64'd1);
    chk("b_bad_novalid", {61'd0, b_cv}, 64'd0);
    @(negedge clk); #1;
    chk("b_bad_err_end", {63'd0, b_err}, 64'd0);
    chk("b_bad_still_empty", {61'd0, b_cv}, 64'd0);

    // 8-channel randomized soak against per-channel queues
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      c_vld = ($urandom_range(0, 3) != 0);
      c_dif = ($urandom_range(0, 15) == 0);
      c_sel = 3'($urandom_range(0, 7));
      c_din = 8'($urandom);
      for (int j = 0; j < 8; j++) c_cp[j] = ($urandom_range(0, 9) < 7);
      #1;
      all_free = 1'b1;
      ecv = '0;
      ecd = '0;
      for (int j = 0; j < 8; j++) begin
        free_v[j] = (sbq[j].size() == 0) || c_cp[j];
        if (!free_v[j]) all_free = 1'b0;
        if (sbq[j].size() != 0) begin
          ecv[j] = 1'b1;
          ecd[j*8 +: 8] = sbq[j][0];
        end
      end
      exp_pr = c_dif ? all_free : free_v[c_sel];
      chk("soak_pronto", {63'd0, c_pr}, {63'd0, exp_pr});
      chk("soak_valid", {56'd0, c_cv}, {56'd0, ecv});
      chk("soak_data", c_cd, ecd);
      chk("soak_err", {63'd0, c_err}, 64'd0);
      @(posedge clk);
      for (int j = 0; j < 8; j++) begin
        if (sbq[j].size() != 0 && c_cp[j]) void'(sbq[j].pop_front());
      end
      if (c_vld && exp_pr) begin
        if (c_dif) begin
          for (int j = 0; j < 8; j++) sbq[j].push_back(c_din);
        end else begin
          sbq[c_sel].push_back(c_din);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/gdemux_router.md
GDEMUX_ROUTER -- requirements
Module: gdemux_router

Interface
REQ-001 Parameter WIDTH, default 16: data width per channel, legal range 1..64.
REQ-002 Parameter CANAIS, default 4: number of output channels, legal range 2..16.
REQ-003 Parameter SEL_W, default 2: selector width; the team SHALL set it to ceil(log2(CANAIS)).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 dados_entrada  input  WIDTH  input word.
REQ-007 controle_sel  input  SEL_W  destination channel index.
REQ-008 difusao  input  1  broadcast mode: word goes to all CANAIS channels.
REQ-009 valido_in  input  1  input word valid.
REQ-010 pronto_in  output  1  block can accept the input word this cycle.
REQ-011 canal_dados  output  CANAIS*WIDTH  channel i data on bits [i*WIDTH +: WIDTH].
REQ-012 canal_valido  output  CANAIS  per-channel output valid.
REQ-013 canal_pronto  input  CANAIS  per-channel consumer ready.
REQ-014 erro_sel  output  1  one-cycle pulse when a word addressed to a non-existent channel is discarded.

Function
REQ-015 Each channel SHALL have one holding register (data plus a full flag); canal_valido[i] SHALL equal the full flag of channel i.
REQ-016 canal_dados slice i SHALL be zero whenever canal_valido[i]=0, and the held word otherwise.
REQ-017 An output transfer SHALL occur on channel i when canal_valido[i] and canal_pronto[i] are both 1 at a clock edge; the full flag of channel i then clears unless it is reloaded on the same edge.
REQ-018 Channel i is "free" SHALL mean: not full, or full and canal_pronto[i]=1 in the same cycle.
REQ-019 Unicast (difusao=0, controle_sel<CANAIS): pronto_in SHALL be 1 exactly when channel controle_sel is free.
REQ-020 Broadcast (difusao=1): pronto_in SHALL be 1 only when all channels are free, and an accepted word SHALL load every channel on the same edge.
REQ-021 An invalid selector (difusao=0, controle_sel>=CANAIS) SHALL force pronto_in=1; the accepted word is discarded, no channel changes, and erro_sel is 1 for exactly the next cycle.
REQ-022 A word is accepted when valido_in and pronto_in are both 1 at an edge; the targeted channel(s) SHALL show the word with canal_valido high in the following cycle (latency 1).
REQ-023 Simultaneous drain and load on the same channel at one edge SHALL leave the channel full with the new word; no bubble and no loss.
REQ-024 pronto_in SHALL depend combinationally only on controle_sel, difusao, the full flags and canal_pronto, never on valido_in.
REQ-025 Channels not targeted by an accepted word SHALL keep their state and data unchanged.
REQ-026 A held word SHALL remain stable until it is transferred, regardless of later input activity.
REQ-027 Transfers SHALL be FIFO per channel with depth 1; the block SHALL NOT reorder, duplicate or drop words except per REQ-021.

Reset
REQ-028 While reset=1, all full flags SHALL be 0, canal_valido=0, canal_dados=0 and erro_sel=0, asynchronously and without waiting for a clock edge.
REQ-029 Reset asserted mid-operation SHALL discard all held words; the first acceptance SHALL be possible on the first clock edge after reset deasserts.
REQ-030 pronto_in during reset SHALL be 0.

Verification
REQ-031 Unicast, all canal_pronto=1: send A5A5 to sel 0, 5A5A to sel 1, FFFF to sel 2, 0000 to sel 3 on consecutive cycles -> each appears one cycle later on its channel only, with canal_valido one-hot; the other slices read 0.
REQ-032 Backpressure, canal_pronto[2]=0: send 1111 then 2222 to sel 2 -> first accepted and second stalled with pronto_in=0; raise canal_pronto[2] -> 1111 drains and 2222 loads on the same edge with no bubble.
REQ-033 Broadcast BEEF with canal_pronto[1]=0 and channel 1 full -> pronto_in=0 and no channel loads; release canal_pronto[1] -> all four channels show BEEF one cycle after acceptance.
REQ-034 CANAIS=3, SEL_W=2: send 1234 to sel 3 -> pronto_in=1, erro_sel pulses for exactly one cycle, and all canal_valido stay 0.
REQ-035 Assert reset asynchronously between edges while channels 0 and 3 are full -> canal_valido and canal_dados go to 0 immediately; after release, a word sent to sel 0 is accepted on the first edge.
REQ-036 WIDTH=8, CANAIS=8 random soak of 10k cycles -> per-channel scoreboard shows order preserved, no loss and no duplication.
